// File: rtl/async_fifo_package.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package async_fifo_package;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import async_fifo_package::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req_valid[(32'(rr_ptr) + i) % NUM_REQ]) begin
        winner  = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granular round-robin arbiter steering NUM_REQ beat streams into one FIFO write port.
module fifo_wr_arbiter
  import async_fifo_package::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_valid,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  input  logic                          fifo_w_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          trunc
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             trunc_q, trunc_d;

  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             own_valid;
  logic             own_last;
  logic             accept;
  logic             at_max;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_id),
    .any_req   (pick_any)
  );

  // Owner mux; handshake is suppressed during reset so nothing is accepted in that cycle.
  always_comb begin
    own_valid    = req_valid[grant_id_q];
    own_last     = req_last[grant_id_q];
    fifo_w_data  = req_data[32'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    fifo_w_valid = 1'b0;
    req_ready    = '0;
    busy         = (state_q == GRANT);
    if (state_q == GRANT && !rst) begin
      fifo_w_valid          = own_valid;
      req_ready[grant_id_q] = fifo_w_ready;
    end
    accept = fifo_w_valid && fifo_w_ready;
    at_max = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (own_last || at_max) begin
            state_d    = IDLE;
            rr_ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
            beat_cnt_d = '0;
            trunc_d    = !own_last;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant_id = grant_id_q;
  assign trunc    = trunc_q;

endmodule
